// File: rtl/delay_scheduler.sv
// rtl/delay_scheduler.sv - shared millisecond-tick one-shot delay scheduler for four requesters
// Round-robin grants one channel at a time; done pulses one cycle when its delay expires.
module delay_scheduler #(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 1000,
  parameter int DW      = 16
) (
  input  logic            clkin,
  input  logic            rst,
  input  logic            clken,
  input  logic [3:0]      req,
  input  logic [4*DW-1:0] dly,
  output logic [3:0]      gnt,
  output logic [3:0]      done,
  output logic            busy,
  output logic            tick,
  output logic [DW-1:0]   remaining
);

  localparam int          TICK_DIV  = CLK_HZ / TICK_HZ;
  localparam logic [31:0] PRESC_TOP = 32'(TICK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        r_state, w_state_nx;
  logic [1:0]    r_ptr, w_ptr_nx;
  logic [1:0]    r_sel, w_sel_nx;
  logic [31:0]   r_presc, w_presc_nx;
  logic [DW-1:0] r_remaining, w_remaining_nx;
  logic [1:0]    w_pick;
  logic          w_found;
  logic [DW-1:0] w_dly_pick;
  logic [3:0]    w_sel_onehot;
  logic          w_tick;

  // Scan downward so the candidate closest to ptr is the last one written and wins.
  always_comb begin
    w_pick  = r_ptr;
    w_found = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (req[r_ptr + 2'(k)]) begin
        w_pick  = r_ptr + 2'(k);
        w_found = 1'b1;
      end
    end
  end

  assign w_dly_pick = dly[DW*w_pick +: DW];
  assign w_tick     = (r_state == S_RUN) && clken && (r_presc == PRESC_TOP);

  always_comb begin
    w_state_nx     = r_state;
    w_ptr_nx       = r_ptr;
    w_sel_nx       = r_sel;
    w_presc_nx     = r_presc;
    w_remaining_nx = r_remaining;
    case (r_state)
      S_IDLE: begin
        w_presc_nx = 32'd0;
        if (w_found) begin
          w_sel_nx       = w_pick;
          w_remaining_nx = w_dly_pick;
          w_state_nx     = (w_dly_pick != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        // A dropped request wins over a final tick in the same cycle.
        if (!req[r_sel]) begin
          w_state_nx     = S_IDLE;
          w_ptr_nx       = r_sel + 2'd1;
          w_remaining_nx = '0;
        end else if (clken) begin
          w_presc_nx = w_tick ? 32'd0 : r_presc + 32'd1;
          if (w_tick && r_remaining != '0) begin
            w_remaining_nx = r_remaining - 1'b1;
            if (r_remaining == DW'(1)) w_state_nx = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_ptr_nx   = r_sel + 2'd1;
        w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= 2'd0;
      r_sel       <= 2'd0;
      r_presc     <= 32'd0;
      r_remaining <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_ptr       <= w_ptr_nx;
      r_sel       <= w_sel_nx;
      r_presc     <= w_presc_nx;
      r_remaining <= w_remaining_nx;
    end
  end

  assign w_sel_onehot = 4'b0001 << r_sel;
  assign gnt          = (r_state != S_IDLE) ? w_sel_onehot : 4'b0000;
  assign done         = (r_state == S_DONE) ? w_sel_onehot : 4'b0000;
  assign busy         = (r_state != S_IDLE);
  assign tick         = w_tick;
  assign remaining    = r_remaining;

endmodule

// File: tb/tb_delay_scheduler.sv
// tb/tb_delay_scheduler.sv - scoreboard bench for delay_scheduler with TICK_DIV=4
module tb_delay_scheduler;

  logic        clkin = 1'b0;
  logic        rst   = 1'b1;
  logic        clken = 1'b1;
  logic [3:0]  req   = 4'b0000;
  logic [63:0] dly   = 64'd0;
  logic [3:0]  gnt, done;
  logic        busy, tick;
  logic [15:0] remaining;

  delay_scheduler #(.CLK_HZ(4000), .TICK_HZ(1000), .DW(16)) dut (
    .clkin(clkin), .rst(rst), .clken(clken), .req(req), .dly(dly),
    .gnt(gnt), .done(done), .busy(busy), .tick(tick), .remaining(remaining)
  );

  always #5 clkin = ~clkin;

  int cyc = 0;
  always @(posedge clkin) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;
  logic [3:0] q_done[$];
  int         q_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
  endtask

  task automatic push(input logic [3:0] d, input int c);
    q_done.push_back(d);
    q_cyc.push_back(c);
  endtask

  task automatic to_cycle(input int n);
    while (cyc < n) @(negedge clkin);
  endtask

  // Monitor: every done pulse must match the next queued completion.
  always @(negedge clkin) begin
    if (done !== 4'b0000) begin
      if (q_done.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_done: got %b expected none at cycle %0d", done, cyc);
      end else begin
        logic [3:0] ed;
        int         ec;
        ed = q_done.pop_front();
        ec = q_cyc.pop_front();
        chk("done_value", done, ed);
        chk("done_gnt", gnt, ed);
        chk("done_cycle", cyc, ec);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int e;
    repeat (2) @(negedge clkin);
    chk("reset_gnt", gnt, 0);
    chk("reset_done", done, 0);
    chk("reset_busy", busy, 0);
    chk("reset_tick", tick, 0);
    chk("reset_remaining", remaining, 0);
    rst = 1'b0;

    // single request, dly0=3
    dly[15:0] = 16'd3;
    req = 4'b0001;
    e = cyc + 1;
    push(4'b0001, e + 12);
    for (int i = 0; i <= 12; i++) begin
      @(negedge clkin);
      chk("single_tick", tick, (i == 3 || i == 7 || i == 11) ? 1 : 0);
      chk("single_remaining", remaining, 3 - i / 4);
      chk("single_gnt", gnt, 4'b0001);
    end
    req = 4'b0000;
    @(negedge clkin);
    chk("single_idle_busy", busy, 0);
    chk("single_idle_gnt", gnt, 0);

    // round robin from reset
    rst = 1'b1;
    @(negedge clkin);
    rst = 1'b0;
    dly = {16'd1, 16'd1, 16'd1, 16'd1};
    req = 4'b1111;
    e = cyc + 1;
    push(4'b0001, e + 4);
    push(4'b0010, e + 10);
    push(4'b0100, e + 16);
    push(4'b1000, e + 22);
    push(4'b0001, e + 28);
    to_cycle(e + 5);
    chk("rr_idle_gap", busy, 0);
    to_cycle(e + 6);
    chk("rr_second_gnt", gnt, 4'b0010);
    to_cycle(e + 28);
    req = 4'b0000;
    @(negedge clkin);

    // zero delay on channel 2
    dly[47:32] = 16'd0;
    req = 4'b0100;
    e = cyc + 1;
    push(4'b0100, e);
    @(negedge clkin);
    chk("zero_gnt", gnt, 4'b0100);
    chk("zero_tick", tick, 0);
    req = 4'b0000;
    @(negedge clkin);
    chk("zero_idle_busy", busy, 0);

    // clken pause of 5 cycles
    dly[15:0] = 16'd2;
    req = 4'b0001;
    e = cyc + 1;
    push(4'b0001, e + 13);
    to_cycle(e + 5);
    clken = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("pause_remaining", remaining, 1);
      chk("pause_tick", tick, 0);
      @(negedge clkin);
    end
    clken = 1'b1;
    to_cycle(e + 13);
    req = 4'b0000;
    @(negedge clkin);

    // abort channel 1, then ptr=2 wraps to channel 0
    dly[31:16] = 16'd5;
    req = 4'b0010;
    e = cyc + 1;
    to_cycle(e + 6);
    chk("abort_gnt_before", gnt, 4'b0010);
    req = 4'b0000;
    @(negedge clkin);
    chk("abort_gnt_after", gnt, 0);
    chk("abort_busy", busy, 0);
    chk("abort_remaining", remaining, 0);
    dly[15:0]  = 16'd1;
    dly[31:16] = 16'd1;
    req = 4'b0011;
    @(negedge clkin);
    chk("abort_next_gnt", gnt, 4'b0001);
    push(4'b0001, e + 12);
    to_cycle(e + 12);
    req = 4'b0000;
    @(negedge clkin);

    // reset in the middle of a channel 3 delay
    dly[63:48] = 16'd3;
    req = 4'b1000;
    e = cyc + 1;
    to_cycle(e + 5);
    chk("rst_pre_gnt", gnt, 4'b1000);
    rst = 1'b1;
    @(negedge clkin);
    chk("rst_mid_gnt", gnt, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_remaining", remaining, 0);
    chk("rst_mid_tick", tick, 0);
    rst = 1'b0;
    @(negedge clkin);
    chk("rst_regrant_gnt", gnt, 4'b1000);
    chk("rst_regrant_remaining", remaining, 3);
    push(4'b1000, e + 19);
    to_cycle(e + 19);
    req = 4'b0000;
    repeat (3) @(negedge clkin);

    chk("scoreboard_empty", q_done.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
